cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter: INVALID_TAG, 5'b11111, tag value meaning "no producer"; never broadcast.
REQ-002 SHALL have parameter: NUM_SRC, 4, number of reservation-station sources (0 ALU, 1 MUL, 2 DIV, 3 LSU); fixed at 4.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: in_req  input  4  per-source result-valid, level, held until acked.
REQ-006 SHALL have port: in_tag  input  20  per-source RS tag, source i at [5i+4:5i].
REQ-007 SHALL have port: in_val  input  128  per-source result, source i at [32i+31:32i].
REQ-008 SHALL have port: in_icc  input  16  per-source {c,v,z,n}, source i at [4i+3:4i].
REQ-009 SHALL have port: in_icc_we  input  4  per-source "result updates ICC".
REQ-010 SHALL have port: in_Y_val  input  32  MUL upper product; meaningful with in_req[1] only.
REQ-011 SHALL have port: out_ack  output  4  per-source one-cycle accept pulse.
REQ-012 SHALL have port: out_CDB_broadcast  output  1  one-cycle bus-valid strobe.
REQ-013 SHALL have port: out_CDB_tag / out_CDB_val  output  5 / 32  broadcast tag and value.
REQ-014 SHALL have port: out_ICC_flags, out_ICC_we  output  4, 1  flags and their write enable.
REQ-015 SHALL have port: out_Y_val, out_Y_we  output  32, 1  Y register update.

Function
REQ-016 SHALL hold one holding slot per source: {full, tag, val, icc, icc_we, Y (slot 1 only)}.
REQ-017 SHALL capture source i at edge when in_req[i]=1 and slot i empty or being granted that same edge; out_ack[i]=1 for exactly the following cycle.
REQ-018 SHALL not re-capture during the ack cycle; source deasserts or presents a new result after seeing ack; a request still high after the ack cycle is treated as new.
REQ-019 SHALL, when captured tag == INVALID_TAG, ack normally, leave slot empty, never broadcast.
REQ-020 SHALL each edge grant at most one full slot, round-robin from pointer rr (2 bits), first full slot at index rr, rr+1, ... mod 4.
REQ-021 SHALL after a grant to slot g set rr = (g+1) mod 4; rr unchanged when no grant.
REQ-022 SHALL on grant register outputs: out_CDB_broadcast=1, tag/val/ICC from slot, out_ICC_we=slot icc_we, out_Y_we=1 only for slot 1, slot cleared; all for exactly one cycle.
REQ-023 SHALL drive out_CDB_broadcast, out_ICC_we, out_Y_we low in cycles without grant; data outputs hold last value.
REQ-024 SHALL have minimum latency req->broadcast of 2 edges (capture, then grant); a slot captured at edge N is grant-eligible at edge N+1.
REQ-025 SHALL sustain one broadcast per cycle when any slot full; no bubble between consecutive grants.
REQ-026 SHALL bound wait: a full slot is granted within 4 edges of becoming full.
REQ-027 SHALL allow capture into slot g on the same edge slot g is granted (back-to-back from one source).
REQ-028 SHALL never broadcast two tags in one cycle nor the same slot contents twice.

Reset
REQ-029 SHALL on rst_n=0 at an edge clear all slots, rr=0, out_ack=0, out_CDB_broadcast=0, out_ICC_we=0, out_Y_we=0, out_CDB_tag=INVALID_TAG, out_CDB_val=0, out_ICC_flags=0, out_Y_val=0.
REQ-030 SHALL discard slot contents and pending grants on reset mid-operation, with no ack or broadcast in the cycle after the reset edge.
REQ-031 SHALL ignore in_req at reset edges; capture resumes at first edge with rst_n=1.

Verification
REQ-032 SHALL pass: single req src0 tag 3 val 0x12345678 -> ack cycle 1, broadcast cycle 2 tag 3 val 0x12345678, ICC_we=in_icc_we[0].
REQ-033 SHALL pass: all 4 sources req together tags 0..3, rr=0 -> broadcasts tags 0,1,2,3 on 4 consecutive cycles; rr ends 0.
REQ-034 SHALL pass: MUL req tag 5 val 0xFFFFFFFE Y 0x00000001 icc_we=1 -> broadcast with out_Y_we=1, Y=1, ICC_we=1.
REQ-035 SHALL pass: req with tag 5'b11111 -> ack pulses, no broadcast within 5 cycles.
REQ-036 SHALL pass: src2 continuous back-to-back reqs while src0 req -> grants alternate 2,0,2,0; neither starves.
REQ-037 SHALL pass: rst_n low one edge with 3 slots full -> no broadcast in following cycles; outputs at reset values.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Result-source and common-data-bus signals between the reservation stations and cdb_arbiter.
// master = the source/consumer side, slave = the arbiter.
interface cdb_arbiter_if ();
  logic [3:0]   in_req;
  logic [19:0]  in_tag;
  logic [127:0] in_val;
  logic [15:0]  in_icc;
  logic [3:0]   in_icc_we;
  logic [31:0]  in_Y_val;

  logic [3:0]   out_ack;
  logic         out_CDB_broadcast;
  logic [4:0]   out_CDB_tag;
  logic [31:0]  out_CDB_val;
  logic [3:0]   out_ICC_flags;
  logic         out_ICC_we;
  logic [31:0]  out_Y_val;
  logic         out_Y_we;

  modport master (
    output in_req, in_tag, in_val, in_icc, in_icc_we, in_Y_val,
    input  out_ack, out_CDB_broadcast, out_CDB_tag, out_CDB_val,
    input  out_ICC_flags, out_ICC_we, out_Y_val, out_Y_we
  );

  modport slave (
    input  in_req, in_tag, in_val, in_icc, in_icc_we, in_Y_val,
    output out_ack, out_CDB_broadcast, out_CDB_tag, out_CDB_val,
    output out_ICC_flags, out_ICC_we, out_Y_val, out_Y_we
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per result source, round-robin grant of one
// full slot per cycle onto the CDB, with registered ack and broadcast outputs.
module cdb_arbiter #(
  parameter logic [4:0]  INVALID_TAG = 5'b11111,
  parameter int unsigned NUM_SRC     = 4
) (
  input logic          clk,
  input logic          rst_n,
  cdb_arbiter_if.slave bus
);

  logic [NUM_SRC-1:0] full_q;
  logic [4:0]         tag_q    [NUM_SRC];
  logic [31:0]        val_q    [NUM_SRC];
  logic [3:0]         icc_q    [NUM_SRC];
  logic [NUM_SRC-1:0] icc_we_q;
  logic [31:0]        y_q;
  logic [1:0]         rr_q;
  logic [NUM_SRC-1:0] ack_q;

  logic        bcast_q;
  logic [4:0]  cdb_tag_q;
  logic [31:0] cdb_val_q;
  logic [3:0]  icc_flags_q;
  logic        icc_we_out_q;
  logic [31:0] y_val_q;
  logic        y_we_q;

  logic [NUM_SRC-1:0] gnt;
  logic [NUM_SRC-1:0] cap;
  logic               gnt_vld;
  logic [1:0]         gnt_idx;
  logic [1:0]         idx;

  // First full slot at rr, rr+1, ... (2-bit index wraps mod 4).
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_q + 2'(k);
      if (!gnt_vld && full_q[idx]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  // A request seen during its own ack cycle is the already-captured one, not a new result.
  always_comb begin
    cap = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cap[i] = bus.in_req[i] && !ack_q[i] && (!full_q[i] || gnt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q       <= '0;
      icc_we_q     <= '0;
      y_q          <= '0;
      rr_q         <= 2'd0;
      ack_q        <= '0;
      bcast_q      <= 1'b0;
      cdb_tag_q    <= INVALID_TAG;
      cdb_val_q    <= '0;
      icc_flags_q  <= '0;
      icc_we_out_q <= 1'b0;
      y_val_q      <= '0;
      y_we_q       <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        tag_q[i] <= INVALID_TAG;
        val_q[i] <= '0;
        icc_q[i] <= '0;
      end
    end else begin
      ack_q <= cap;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cap[i]) begin
          // An invalid tag is acked but never occupies the slot.
          full_q[i]   <= (bus.in_tag[5*i +: 5] != INVALID_TAG);
          tag_q[i]    <= bus.in_tag[5*i +: 5];
          val_q[i]    <= bus.in_val[32*i +: 32];
          icc_q[i]    <= bus.in_icc[4*i +: 4];
          icc_we_q[i] <= bus.in_icc_we[i];
        end else if (gnt[i]) begin
          full_q[i] <= 1'b0;
        end
      end
      if (cap[1]) begin
        y_q <= bus.in_Y_val;
      end

      bcast_q      <= gnt_vld;
      icc_we_out_q <= gnt_vld && icc_we_q[gnt_idx];
      y_we_q       <= gnt_vld && (gnt_idx == 2'd1);
      if (gnt_vld) begin
        rr_q        <= gnt_idx + 2'd1;
        cdb_tag_q   <= tag_q[gnt_idx];
        cdb_val_q   <= val_q[gnt_idx];
        icc_flags_q <= icc_q[gnt_idx];
        if (gnt_idx == 2'd1) begin
          y_val_q <= y_q;
        end
      end
    end
  end

  assign bus.out_ack           = ack_q;
  assign bus.out_CDB_broadcast = bcast_q;
  assign bus.out_CDB_tag       = cdb_tag_q;
  assign bus.out_CDB_val       = cdb_val_q;
  assign bus.out_ICC_flags     = icc_flags_q;
  assign bus.out_ICC_we        = icc_we_out_q;
  assign bus.out_Y_val         = y_val_q;
  assign bus.out_Y_we          = y_we_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed broadcast sequences checked one cycle at a
// time, sampled 1 time unit after each rising edge.
module tb_cdb_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  cdb_arbiter_if u_if ();

  cdb_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", name, obs, exp);
  endtask

  task automatic set_src(input int i, input logic [4:0] tag, input logic [31:0] val,
                         input logic [3:0] icc, input logic icc_we);
    u_if.in_req[i]          = 1'b1;
    u_if.in_tag[5*i +: 5]   = tag;
    u_if.in_val[32*i +: 32] = val;
    u_if.in_icc[4*i +: 4]   = icc;
    u_if.in_icc_we[i]       = icc_we;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_bcast(input string name, input logic [4:0] tag, input logic [31:0] val);
    chk({name, "_bcast"}, 32'(u_if.out_CDB_broadcast), 32'd1);
    chk({name, "_tag"}, 32'(u_if.out_CDB_tag), 32'(tag));
    chk({name, "_val"}, u_if.out_CDB_val, val);
  endtask

  initial begin
    n_chk            = 0;
    n_pass           = 0;
    rst_n            = 1'b0;
    u_if.in_req      = '0;
    u_if.in_tag      = '0;
    u_if.in_val      = '0;
    u_if.in_icc      = '0;
    u_if.in_icc_we   = '0;
    u_if.in_Y_val    = '0;
    step();
    step();
    chk("rst_ack", 32'(u_if.out_ack), 32'd0);
    chk("rst_bcast", 32'(u_if.out_CDB_broadcast), 32'd0);
    chk("rst_tag", 32'(u_if.out_CDB_tag), 32'h1f);
    chk("rst_val", u_if.out_CDB_val, 32'd0);
    rst_n = 1'b1;

    // Single request from ALU.
    set_src(0, 5'd3, 32'h1234_5678, 4'b0101, 1'b1);
    step();
    chk("single_ack", 32'(u_if.out_ack), 32'b0001);
    chk("single_nobcast", 32'(u_if.out_CDB_broadcast), 32'd0);
    u_if.in_req = '0;
    step();
    chk_bcast("single", 5'd3, 32'h1234_5678);
    chk("single_icc_we", 32'(u_if.out_ICC_we), 32'd1);
    chk("single_icc", 32'(u_if.out_ICC_flags), 32'b0101);
    chk("single_y_we", 32'(u_if.out_Y_we), 32'd0);
    step();
    chk("single_done", 32'(u_if.out_CDB_broadcast), 32'd0);
    chk("single_hold_tag", 32'(u_if.out_CDB_tag), 32'd3);
    chk("single_icc_we_lo", 32'(u_if.out_ICC_we), 32'd0);

    // All four sources at once from rr=0.
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 5'(i), 32'hA000_0000 + 32'(i), 4'(i), 1'b0);
    step();
    chk("all_ack", 32'(u_if.out_ack), 32'hf);
    u_if.in_req = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_bcast("all", 5'(i), 32'hA000_0000 + 32'(i));
      chk("all_ack_lo", 32'(u_if.out_ack), 32'd0);
    end
    step();
    chk("all_done", 32'(u_if.out_CDB_broadcast), 32'd0);

    // rr must be back at 0: sources 3 and 1 together grant 1 first.
    set_src(3, 5'd13, 32'h33, 4'd0, 1'b0);
    set_src(1, 5'd11, 32'h11, 4'd0, 1'b0);
    step();
    u_if.in_req = '0;
    step();
    chk_bcast("rr0_first", 5'd11, 32'h11);
    step();
    chk_bcast("rr0_second", 5'd13, 32'h33);

    // MUL result with Y.
    set_src(1, 5'd5, 32'hFFFF_FFFE, 4'b1010, 1'b1);
    u_if.in_Y_val = 32'h0000_0001;
    step();
    chk("mul_ack", 32'(u_if.out_ack), 32'b0010);
    u_if.in_req = '0;
    step();
    chk_bcast("mul", 5'd5, 32'hFFFF_FFFE);
    chk("mul_y_we", 32'(u_if.out_Y_we), 32'd1);
    chk("mul_y_val", u_if.out_Y_val, 32'd1);
    chk("mul_icc_we", 32'(u_if.out_ICC_we), 32'd1);
    chk("mul_icc", 32'(u_if.out_ICC_flags), 32'b1010);
    step();
    chk("mul_y_we_lo", 32'(u_if.out_Y_we), 32'd0);

    // Invalid tag: acked, never broadcast.
    set_src(0, 5'b11111, 32'hDEAD_BEEF, 4'hf, 1'b1);
    step();
    chk("inv_ack", 32'(u_if.out_ack), 32'b0001);
    u_if.in_req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("inv_nobcast", 32'(u_if.out_CDB_broadcast), 32'd0);
    end

    // src2 continuous, src0 joins a cycle later: grants alternate 2,0,2,0.
    do_reset();
    set_src(2, 5'd2, 32'h0000_0022, 4'b0011, 1'b1);
    step();
    set_src(0, 5'd0, 32'h0000_0010, 4'b0110, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i % 2 == 0) chk_bcast("alt_src2", 5'd2, 32'h22);
      else            chk_bcast("alt_src0", 5'd0, 32'h10);
    end
    u_if.in_req = '0;
    step();
    chk_bcast("alt_drain", 5'd2, 32'h22);
    step();
    step();

    // Reset with three slots full; requests still high at the reset edge.
    set_src(0, 5'd10, 32'h100, 4'd1, 1'b1);
    set_src(1, 5'd11, 32'h101, 4'd2, 1'b1);
    set_src(3, 5'd13, 32'h103, 4'd3, 1'b1);
    u_if.in_Y_val = 32'h5555_5555;
    step();
    chk("rst3_ack", 32'(u_if.out_ack), 32'b1011);
    rst_n = 1'b0;
    step();
    chk("rst3_ack_lo", 32'(u_if.out_ack), 32'd0);
    chk("rst3_bcast", 32'(u_if.out_CDB_broadcast), 32'd0);
    chk("rst3_tag", 32'(u_if.out_CDB_tag), 32'h1f);
    chk("rst3_val", u_if.out_CDB_val, 32'd0);
    chk("rst3_icc", 32'(u_if.out_ICC_flags), 32'd0);
    chk("rst3_icc_we", 32'(u_if.out_ICC_we), 32'd0);
    chk("rst3_y_val", u_if.out_Y_val, 32'd0);
    chk("rst3_y_we", 32'(u_if.out_Y_we), 32'd0);
    u_if.in_req = '0;
    rst_n       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst3_nobcast", 32'(u_if.out_CDB_broadcast), 32'd0);
      chk("rst3_noack", 32'(u_if.out_ack), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
